r_type_seq_ctrl: RTL

//  Multi-cycle sequencer for the R-type CPU: fetches each instruction, decodes OP/func into the 3-bit ALU op
//  and drives register-file read/write control around the shared ALU. Sits between the instruction memory
//  and the datapath (register file + ALU), one instruction in flight at a time.

---
 rtl/r_type_seq_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/r_type_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/write-back sequencer for the R-type CPU.
// Optional retire counter output enabled by defining RTYPE_RETIRE_CNT_EN.
module r_type_seq_ctrl #(
    parameter int unsigned     PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            halt_req,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      rd,
    output logic [2:0]      alu_op,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            trap
`ifdef RTYPE_RETIRE_CNT_EN
    ,
    output logic [31:0]     retire_cnt
`endif
);

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned ALU_W   = 3;
    localparam int unsigned OPC_W   = 6;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;

    logic                dec_legal;
    logic [ALU_W-1:0]    dec_op;

    logic                imem_req_d;
    logic [PC_W-1:0]     imem_addr_d;
    logic [ALU_W-1:0]    alu_op_d;
    logic                rf_we_d;
    logic [REG_W-1:0]    rf_waddr_d;
    logic                busy_d;
    logic                trap_d;

    // Maps the func field to {legal, alu_op}.
    function automatic logic [ALU_W:0] decode_func(input logic [5:0] func);
        logic [ALU_W:0] r;
        r = '0;
        case (func)
            6'b100000: r = {1'b1, 3'b100};
            6'b100010: r = {1'b1, 3'b101};
            6'b100100: r = {1'b1, 3'b000};
            6'b100101: r = {1'b1, 3'b001};
            6'b100110: r = {1'b1, 3'b010};
            6'b100111: r = {1'b1, 3'b011};
            6'b101011: r = {1'b1, 3'b110};
            6'b000100: r = {1'b1, 3'b111};
            default:   r = '0;
        endcase
        return r;
    endfunction

    // IR only changes on the FETCH->DECODE edge, so decoding ir_q is valid for DECODE/EXEC/WB.
    assign {dec_legal, dec_op} = decode_func(ir_q[5:0]);

    // The shamt field is not needed by this instruction subset.
    logic unused_shamt;
    assign unused_shamt = ^ir_q[10:6];

    // Next state plus next-cycle Moore outputs, so every output comes straight from a flop.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        imem_req_d  = 1'b0;
        imem_addr_d = '0;
        alu_op_d    = '0;
        rf_we_d     = 1'b0;
        rf_waddr_d  = '0;
        busy_d      = 1'b0;
        trap_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    pc_d    = pc_q + PC_W'(4);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_legal && (ir_q[31:26] == OPC_W'(0))) state_d = S_EXEC;
                else                                         state_d = S_TRAP;
            end
            S_EXEC: state_d = S_WB;
            S_WB: begin
                if (halt_req) state_d = S_IDLE;
                else          state_d = S_FETCH;
            end
            S_TRAP: begin
                if (start) state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_FETCH: begin
                imem_req_d  = 1'b1;
                imem_addr_d = pc_d;
                busy_d      = 1'b1;
            end
            S_DECODE: busy_d = 1'b1;
            S_EXEC: begin
                alu_op_d = dec_op;
                busy_d   = 1'b1;
            end
            S_WB: begin
                alu_op_d   = dec_op;
                rf_waddr_d = ir_d[15:11];
                rf_we_d    = (ir_d[15:11] != REG_W'(0));
                busy_d     = 1'b1;
            end
            S_TRAP:  trap_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            alu_op    <= '0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            busy      <= 1'b0;
            trap      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            imem_req  <= imem_req_d;
            imem_addr <= imem_addr_d;
            alu_op    <= alu_op_d;
            rf_we     <= rf_we_d;
            rf_waddr  <= rf_waddr_d;
            busy      <= busy_d;
            trap      <= trap_d;
        end
    end

    assign pc = pc_q;
    assign rs = ir_q[25:21];
    assign rt = ir_q[20:16];
    assign rd = ir_q[15:11];

`ifdef RTYPE_RETIRE_CNT_EN
    // Counts every WB cycle, including writes suppressed for r0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               retire_cnt <= '0;
        else if (state_q == S_WB) retire_cnt <= retire_cnt + 32'd1;
    end
`else
    // No retire counter in this build.
`endif

endmodule
